// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-entry stage with valid/ready handshakes on both sides.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier (opcode 1000).
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             busy;
    logic             accept;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CNT_W  = $clog2(XLEN);

    typedef enum logic {IDLE, MUL_BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  acc_next;

    assign busy     = (state_q == MUL_BUSY);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !rst && !flush && !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch below can infer a latch.
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        tag_d       = tag_q;
`ifdef ALU_EXEC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_d = IDLE;
            cnt_d   = '0;
`endif
        end else begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;

            if (accept) begin
                out_valid_d = 1'b1;
                illegal_d   = 1'b0;
                tag_d       = tag_in;
                case (operation)
                    OP_AND: result_d = op_a & op_b;
                    OP_OR:  result_d = op_a | op_b;
                    OP_ADD: result_d = op_a + op_b;
                    OP_SUB: result_d = op_a - op_b;
`ifdef ALU_EXEC_MUL_EN
                    OP_MUL: begin
                        out_valid_d = 1'b0;
                        state_d     = MUL_BUSY;
                        cnt_d       = '0;
                        mcand_d     = op_a;
                        mplier_d    = op_b;
                        acc_d       = '0;
                    end
`endif
                    default: begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
                endcase
                zero_d = (result_d == '0);
            end

`ifdef ALU_EXEC_MUL_EN
            // One multiplier bit per cycle; the last step writes straight into the result.
            if (busy) begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            tag_q       <= '0;
`ifdef ALU_EXEC_MUL_EN
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            tag_q       <= tag_d;
`ifdef ALU_EXEC_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign tag_out   = tag_q;

endmodule
